// File: rtl/ternary_seq_ctrl.sv
// rtl/ternary_seq_ctrl.sv - weight loader and vector beat sequencer for the ternary MVM stage
// Optional config-byte parity check: define TERNARY_CFG_PARITY_EN.
module ternary_seq_ctrl #(
  parameter  int InLen    = 14,
  parameter  int BitWidth = 8,
  parameter  int NumRows  = 8,
  localparam int RowW     = (NumRows > 1) ? $clog2(NumRows) : 1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  en,
  input  logic                  cfg_load,
  input  logic [7:0]            cfg_data,
  input  logic                  cfg_parity,
  input  logic                  vec_valid,
  input  logic [2*BitWidth-1:0] vec_in,
  output logic                  vec_ready,
  output logic [2*InLen-1:0]    w_out,
  output logic [2*BitWidth-1:0] vec_out,
  output logic [RowW-1:0]       row,
  output logic                  w_ready,
  output logic                  busy,
  output logic                  frame_done,
  output logic                  cfg_err
);

  localparam int WBits  = 2 * InLen;
  localparam int NBytes = (WBits + 7) / 8;
  localparam int CntW   = (NBytes > 1) ? $clog2(NBytes) : 1;
  localparam int VW     = 2 * BitWidth;

  localparam logic [CntW-1:0] LastByte = CntW'(NBytes - 1);
  localparam logic [RowW-1:0] LastRow  = RowW'(NumRows - 1);

  logic [WBits-1:0]    w_q, w_d;
  logic [8*NBytes-1:0] shadow_q, shadow_d;
  logic [CntW-1:0]     byte_cnt_q, byte_cnt_d;
  logic [RowW-1:0]     row_q, row_d;
  logic [RowW-1:0]     beat_q, beat_d;
  logic [VW-1:0]       vec_q, vec_d;
  logic                w_ready_q, w_ready_d;
  logic                busy_q, busy_d;
  logic                frame_done_q, frame_done_d;

  logic cfg_acc;
  logic vec_acc;
  logic par_bad;

  // Config is only taken between frames; beats need a complete weight set and no load in flight.
  assign cfg_acc   = en & ~busy_q & cfg_load;
  assign vec_ready = en & w_ready_q & (byte_cnt_q == '0) & ~cfg_load;
  assign vec_acc   = vec_valid & vec_ready;

`ifdef TERNARY_CFG_PARITY_EN
  logic cfg_err_q, cfg_err_d;

  assign par_bad = ^{cfg_data, cfg_parity};

  // Sticky parity error: set on a bad byte, cleared by the next complete load.
  always_comb begin
    cfg_err_d = cfg_err_q;
    if (cfg_acc) begin
      if (par_bad) begin
        cfg_err_d = 1'b1;
      end else if (byte_cnt_q == LastByte) begin
        cfg_err_d = 1'b0;
      end
    end
  end

  // Parity error flag register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cfg_err_q <= 1'b0;
    end else begin
      cfg_err_q <= cfg_err_d;
    end
  end

  assign cfg_err = cfg_err_q;
`else
  logic unused_cfg_parity;
  assign unused_cfg_parity = cfg_parity;
  assign par_bad           = 1'b0;
  assign cfg_err           = 1'b0;
`endif

  // Next-state for byte assembly, weight commit and beat sequencing; en=0 holds everything.
  always_comb begin
    w_d          = w_q;
    shadow_d     = shadow_q;
    byte_cnt_d   = byte_cnt_q;
    row_d        = row_q;
    beat_d       = beat_q;
    vec_d        = vec_q;
    w_ready_d    = w_ready_q;
    busy_d       = busy_q;
    frame_done_d = frame_done_q;
    if (en) begin
      frame_done_d = 1'b0;
      if (cfg_acc) begin
        if (par_bad) begin
          byte_cnt_d = '0;
          w_ready_d  = 1'b0;
        end else begin
          for (int i = 0; i < NBytes; i++) begin
            if (byte_cnt_q == CntW'(i)) begin
              shadow_d[8*i +: 8] = cfg_data;
            end
          end
          w_ready_d = 1'b0;
          if (byte_cnt_q == LastByte) begin
            // Commit only the complete set; bits above WBits are dropped here.
            w_d        = shadow_d[WBits-1:0];
            w_ready_d  = 1'b1;
            byte_cnt_d = '0;
          end else begin
            byte_cnt_d = byte_cnt_q + CntW'(1);
          end
        end
      end
      if (vec_acc) begin
        vec_d        = vec_in;
        row_d        = beat_q;
        beat_d       = (beat_q == LastRow) ? '0 : beat_q + RowW'(1);
        busy_d       = (beat_q != LastRow);
        frame_done_d = (beat_q == LastRow);
      end else if (row_q != '0) begin
        // Mid-frame bubble: feed zeros so the accumulator adds nothing.
        vec_d = '0;
      end
    end
  end

  // State registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      w_q          <= '0;
      shadow_q     <= '0;
      byte_cnt_q   <= '0;
      row_q        <= '0;
      beat_q       <= '0;
      vec_q        <= '0;
      w_ready_q    <= 1'b0;
      busy_q       <= 1'b0;
      frame_done_q <= 1'b0;
    end else begin
      w_q          <= w_d;
      shadow_q     <= shadow_d;
      byte_cnt_q   <= byte_cnt_d;
      row_q        <= row_d;
      beat_q       <= beat_d;
      vec_q        <= vec_d;
      w_ready_q    <= w_ready_d;
      busy_q       <= busy_d;
      frame_done_q <= frame_done_d;
    end
  end

  assign w_out      = w_q;
  assign vec_out    = vec_q;
  assign row        = row_q;
  assign w_ready    = w_ready_q;
  assign busy       = busy_q;
  assign frame_done = frame_done_q;

endmodule

// File: tb/tb_ternary_seq_ctrl.sv
// tb/tb_ternary_seq_ctrl.sv - self-checking bench for ternary_seq_ctrl
module tb_ternary_seq_ctrl;

  localparam int WB     = 28;
  localparam int VW     = 16;
  localparam int NR     = 8;
  localparam int NBYTES = 4;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          en = 1'b0;
  logic          cfg_load = 1'b0;
  logic [7:0]    cfg_data = '0;
  logic          cfg_parity = 1'b0;
  logic          vec_valid = 1'b0;
  logic [VW-1:0] vec_in = '0;
  logic          vec_ready;
  logic [WB-1:0] w_out;
  logic [VW-1:0] vec_out;
  logic [2:0]    row;
  logic          w_ready, busy, frame_done, cfg_err;

  int checks = 0;
  int errors = 0;

  // Reference model state
  logic [WB-1:0] m_w;
  logic [7:0]    m_bytes[$];
  logic          m_w_ready, m_busy, m_fd, m_err;
  int            m_pos, m_row;
  logic [VW-1:0] m_vec;

  ternary_seq_ctrl dut (
    .clk(clk), .rst_n(rst_n), .en(en), .cfg_load(cfg_load), .cfg_data(cfg_data),
    .cfg_parity(cfg_parity), .vec_valid(vec_valid), .vec_in(vec_in), .vec_ready(vec_ready),
    .w_out(w_out), .vec_out(vec_out), .row(row), .w_ready(w_ready), .busy(busy),
    .frame_done(frame_done), .cfg_err(cfg_err)
  );

  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog time limit reached");
    $fatal(1);
  end

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", name, got, exp);
    end
  endtask

  task automatic model_reset();
    m_w = '0; m_bytes.delete(); m_w_ready = 0; m_busy = 0; m_fd = 0; m_err = 0;
    m_pos = 0; m_row = 0; m_vec = '0;
  endtask

  task automatic check_outs();
    chk("w_out", w_out, m_w);
    chk("vec_out", vec_out, m_vec);
    chk("row", row, m_row);
    chk("w_ready", w_ready, m_w_ready);
    chk("busy", busy, m_busy);
    chk("frame_done", frame_done, m_fd);
    chk("cfg_err", cfg_err, m_err);
  endtask

  // One clock: drive at negedge, check ready, clock, advance model, check registers.
  task automatic step(input logic e, input logic cl, input logic [7:0] cd, input logic cp,
                      input logic vv, input logic [VW-1:0] vi);
    logic exp_rdy, bad;
    logic [63:0] acc;
    @(negedge clk);
    en = e; cfg_load = cl; cfg_data = cd; cfg_parity = cp; vec_valid = vv; vec_in = vi;
    #1;
    exp_rdy = e && m_w_ready && (m_bytes.size() == 0) && !cl;
    chk("vec_ready", vec_ready, exp_rdy);
    @(posedge clk);
    if (e) begin
      m_fd = 0;
      if (cl && !m_busy) begin
        bad = 1'b0;
`ifdef TERNARY_CFG_PARITY_EN
        bad = ^{cd, cp};
`endif
        if (bad) begin
          m_bytes.delete(); m_w_ready = 0; m_err = 1;
        end else begin
          m_bytes.push_back(cd);
          m_w_ready = 0;
          if (m_bytes.size() == NBYTES) begin
            acc = '0;
            foreach (m_bytes[k]) acc = acc | (64'(m_bytes[k]) << (8 * k));
            m_w = acc[WB-1:0];
            m_w_ready = 1; m_err = 0;
            m_bytes.delete();
          end
        end
      end
      if (vv && exp_rdy) begin
        m_vec = vi;
        m_row = m_pos;
        m_fd  = (m_pos == NR - 1);
        m_pos = (m_pos + 1) % NR;
        m_busy = (m_pos != 0);
      end else if (m_row != 0) begin
        m_vec = '0;
      end
    end
    #1;
    check_outs();
  endtask

  task automatic cfg(input logic [7:0] b);
    step(1, 1, b, ^b, 0, '0);
  endtask

  task automatic beat(input logic [VW-1:0] v);
    step(1, 0, 8'h00, 0, 1, v);
  endtask

  task automatic idle();
    step(1, 0, 8'h00, 0, 0, '0);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 0; en = 0; cfg_load = 0; vec_valid = 0;
    #1;
    model_reset();
    chk("rst_w_out", w_out, 0);
    chk("rst_vec_out", vec_out, 0);
    chk("rst_row", row, 0);
    chk("rst_w_ready", w_ready, 0);
    chk("rst_busy", busy, 0);
    chk("rst_frame_done", frame_done, 0);
    chk("rst_cfg_err", cfg_err, 0);
    @(negedge clk);
    rst_n = 1;
  endtask

  typedef struct {
    logic          cl;
    logic [7:0]    cd;
    logic          vv;
    logic [VW-1:0] vi;
    logic [WB-1:0] ew;
    logic          ewr;
    logic [2:0]    erow;
    logic [VW-1:0] evec;
    logic          efd;
    logic          ebusy;
  } vec_t;

  vec_t tbl[12];
  logic [7:0] cfg_bytes[4];

  initial begin
    cfg_bytes[0] = 8'h5D; cfg_bytes[1] = 8'hC3; cfg_bytes[2] = 8'h31; cfg_bytes[3] = 8'hF7;
    for (int i = 0; i < 4; i++) begin
      tbl[i] = '{cl: 1, cd: cfg_bytes[i], vv: 0, vi: '0,
                 ew: (i == 3) ? 28'h731C35D : 28'h0, ewr: (i == 3),
                 erow: 3'd0, evec: '0, efd: 0, ebusy: 0};
    end
    for (int i = 0; i < 8; i++) begin
      tbl[4+i] = '{cl: 0, cd: 8'h00, vv: 1, vi: 16'h0102 + 16'(i) * 16'h0101,
                   ew: 28'h731C35D, ewr: 1, erow: 3'(i),
                   evec: 16'h0102 + 16'(i) * 16'h0101, efd: (i == 7), ebusy: (i != 7)};
    end

    model_reset();
    #1;
    chk("init_w_out", w_out, 0);
    chk("init_w_ready", w_ready, 0);
    chk("init_row", row, 0);
    chk("init_vec_out", vec_out, 0);
    @(negedge clk);
    rst_n = 1;

    // Weight load followed by a full back-to-back frame
    foreach (tbl[i]) begin
      step(1, tbl[i].cl, tbl[i].cd, ^tbl[i].cd, tbl[i].vv, tbl[i].vi);
      chk($sformatf("tbl%0d_w_out", i), w_out, tbl[i].ew);
      chk($sformatf("tbl%0d_w_ready", i), w_ready, tbl[i].ewr);
      chk($sformatf("tbl%0d_row", i), row, tbl[i].erow);
      chk($sformatf("tbl%0d_vec_out", i), vec_out, tbl[i].evec);
      chk($sformatf("tbl%0d_frame_done", i), frame_done, tbl[i].efd);
      chk($sformatf("tbl%0d_busy", i), busy, tbl[i].ebusy);
    end

    // Mid-frame bubble after beat 3 feeds zeros with row held
    for (int i = 0; i < 4; i++) beat(16'h1100 + 16'(i));
    for (int i = 0; i < 2; i++) begin
      idle();
      chk("bub3_row", row, 3);
      chk("bub3_vec_out", vec_out, 0);
    end
    beat(16'h1104);
    chk("bub3_resume_row", row, 4);
    for (int i = 5; i < 8; i++) beat(16'h1100 + 16'(i));
    chk("bub3_frame_done", frame_done, 1);

    // Bubble at row 0 holds the first beat value
    beat(16'hAAAA);
    for (int i = 0; i < 3; i++) begin
      idle();
      chk("bub0_row", row, 0);
      chk("bub0_vec_out", vec_out, 16'hAAAA);
      chk("bub0_busy", busy, 1);
    end
    for (int i = 1; i < 8; i++) beat(16'h2200 + 16'(i));

    // Config byte while busy is dropped; config beats a simultaneous beat when idle
    beat(16'h1234);
    step(1, 1, 8'h00, 0, 1, 16'h5555);
    chk("busy_cfg_w_out", w_out, 28'h731C35D);
    chk("busy_cfg_w_ready", w_ready, 1);
    for (int i = 1; i < 8; i++) beat(16'h3300 + 16'(i));
    step(1, 1, 8'hA5, 0, 1, 16'h7777);
    chk("cfg_wins_w_ready", w_ready, 0);
    chk("cfg_wins_row", row, 7);
    cfg(8'h3C); cfg(8'h96); cfg(8'h0F);
    chk("reload_w_out", w_out, 28'hF963CA5);
    chk("reload_w_ready", w_ready, 1);

    // Reset during a partial load, then a clean load
    cfg(8'h11); cfg(8'h22);
    do_reset();
    foreach (cfg_bytes[i]) cfg(cfg_bytes[i]);
    chk("post_rst_w_out", w_out, 28'h731C35D);
    chk("post_rst_w_ready", w_ready, 1);

`ifdef TERNARY_CFG_PARITY_EN
    cfg(8'h01); cfg(8'h02);
    step(1, 1, 8'h03, ~(^8'h03), 0, '0);
    chk("par_cfg_err", cfg_err, 1);
    chk("par_w_ready", w_ready, 0);
    foreach (cfg_bytes[i]) cfg(cfg_bytes[i]);
    chk("par_clear_cfg_err", cfg_err, 0);
`endif

    // Randomized traffic against the model
    for (int n = 0; n < 3000; n++) begin
      logic [7:0] d;
      logic       p;
      if ($urandom_range(0, 199) == 0) begin
        do_reset();
      end else begin
        d = 8'($urandom);
        p = ^d;
`ifdef TERNARY_CFG_PARITY_EN
        if ($urandom_range(0, 19) == 0) p = ~p;
`else
        if ($urandom_range(0, 1) == 0) p = ~p;
`endif
        step($urandom_range(0, 9) != 0, $urandom_range(0, 14) == 0, d, p,
             $urandom_range(0, 9) < 6, 16'($urandom));
      end
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
